// File: rtl/eeprom_access_arbiter.sv
// eeprom_access_arbiter
// Shares the single EEPROM backing block-RAM port between the console
// serial-command engine (port A: word read, word write, fill-all) and the
// MCU bulk load/dump port (port B: single-word read or write).
// Round-robin arbitration, per-size address masking, a registered RAM port
// and bounded-latency yielding to B during long fills.
// Optional dirty-block tracking (DirtyMask/DirtyClr) is built only when the
// macro EEPROM_DIRTY_TRACK_EN is defined; the default build omits it.
module eeprom_access_arbiter #(
  parameter int YIELD_INTERVAL = 16,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                  SClk,
  input  logic                  nReset,
  input  logic [1:0]            EEPROMSize,
  input  logic                  AReq,
  input  logic [1:0]            AOp,
  input  logic [ADDR_WIDTH-1:0] AAddr,
  input  logic [15:0]           AData,
  output logic                  AAck,
  output logic [15:0]           ARData,
  input  logic                  BReq,
  input  logic                  BWrite,
  input  logic [ADDR_WIDTH-1:0] BAddr,
  input  logic [15:0]           BData,
  output logic                  BAck,
  output logic [15:0]           BRData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [15:0]           MemWData,
  output logic                  MemWe,
  output logic                  MemRe,
  input  logic [15:0]           MemRData,
  output logic                  Busy
`ifdef EEPROM_DIRTY_TRACK_EN
  ,
  output logic [15:0]           DirtyMask,
  input  logic [15:0]           DirtyClr
`endif
);

  // Width of the words-since-last-yield-check counter.
  localparam int YW = (YIELD_INTERVAL > 1) ? $clog2(YIELD_INTERVAL) : 1;
  localparam logic [YW-1:0]         YIELD_LAST     = YW'(YIELD_INTERVAL - 1);
  localparam logic [YW-1:0]         YIELD_ZERO     = {YW{1'b0}};
  localparam logic [YW-1:0]         YIELD_ONE      = YW'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO      = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE       = ADDR_WIDTH'(1'b1);
  localparam logic [15:0]           NO_EEPROM_DATA = 16'hFFFF;
  localparam logic [1:0]            SIZE_NONE      = 2'd3;
  localparam logic [1:0]            OP_READ        = 2'd0;
  localparam logic [1:0]            OP_FILL        = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACC_WR    = 3'd1,
    ST_ACC_RD    = 3'd2,
    ST_RD_WAIT   = 3'd3,
    ST_FILL      = 3'd4,
    ST_YIELD_WR  = 3'd5,
    ST_YIELD_RD  = 3'd6,
    ST_YIELD_RDW = 3'd7
  } state_t;

  // Address mask for each EEPROMSize code; "no EEPROM" keeps the full range.
  function automatic logic [ADDR_WIDTH-1:0] size_mask(input logic [1:0] size);
    logic [ADDR_WIDTH-1:0] m;
    case (size)
      2'd0:    m = ADDR_WIDTH'(10'h03F);
      2'd1:    m = ADDR_WIDTH'(10'h1FF);
      2'd2:    m = ADDR_WIDTH'(10'h3FF);
      default: m = ADDR_WIDTH'(10'h3FF);
    endcase
    return m;
  endfunction

  // Read data as seen by a requester: an absent EEPROM reads as all ones.
  function automatic logic [15:0] read_value(input logic [1:0] size, input logic [15:0] raw);
    logic [15:0] v;
    if (size == SIZE_NONE) begin
      v = NO_EEPROM_DATA;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  state_t state_r, state_s;

  logic                  last_grant_a_r, last_grant_a_s;
  logic                  side_a_r, side_a_s;
  logic [1:0]            size_r, size_s;
  logic [ADDR_WIDTH-1:0] mask_r, mask_s;
  logic [15:0]           fill_data_r, fill_data_s;
  logic [ADDR_WIDTH-1:0] fill_cnt_r, fill_cnt_s;
  logic [YW-1:0]         yield_cnt_r, yield_cnt_s;

  logic                  a_ack_r, a_ack_s;
  logic                  b_ack_r, b_ack_s;
  logic [15:0]           a_rdata_r, a_rdata_s;
  logic [15:0]           b_rdata_r, b_rdata_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [15:0]           mem_wdata_r, mem_wdata_s;
  logic                  mem_we_r, mem_we_s;
  logic                  mem_re_r, mem_re_s;
  logic                  busy_r, busy_s;

  logic [ADDR_WIDTH-1:0] in_mask_s;
  logic                  a_elig_s, b_elig_s;
  logic                  grant_a_s, grant_b_s;
  logic                  fill_last_s, yield_go_s, fill_we_s;

  // A requester whose ack is showing this cycle is finishing, not asking again.
  assign a_elig_s    = AReq & ~a_ack_r;
  assign b_elig_s    = BReq & ~b_ack_r;
  assign grant_a_s   = a_elig_s & (~b_elig_s | ~last_grant_a_r);
  assign grant_b_s   = b_elig_s & ~grant_a_s;
  assign in_mask_s   = size_mask(EEPROMSize);
  assign fill_last_s = (fill_cnt_r == mask_r);
  assign yield_go_s  = (yield_cnt_r == YIELD_LAST) & b_elig_s;
  assign fill_we_s   = (size_r != SIZE_NONE);

  // State register.
  always_ff @(posedge SClk) begin
    if (!nReset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_a_s) begin
          if (AOp == OP_READ) begin
            state_s = ST_ACC_RD;
          end else if (AOp == OP_FILL) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_ACC_WR;
          end
        end else if (grant_b_s) begin
          if (BWrite) begin
            state_s = ST_ACC_WR;
          end else begin
            state_s = ST_ACC_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACC_WR:    state_s = ST_IDLE;
      ST_ACC_RD:    state_s = ST_RD_WAIT;
      ST_RD_WAIT:   state_s = ST_IDLE;
      ST_FILL: begin
        if (fill_last_s) begin
          state_s = ST_IDLE;
        end else if (yield_go_s) begin
          if (BWrite) begin
            state_s = ST_YIELD_WR;
          end else begin
            state_s = ST_YIELD_RD;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_YIELD_WR:  state_s = ST_FILL;
      ST_YIELD_RD:  state_s = ST_YIELD_RDW;
      ST_YIELD_RDW: state_s = ST_FILL;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Next values of the RAM port, acks, read data and operand latches.
  always_comb begin
    last_grant_a_s = last_grant_a_r;
    side_a_s       = side_a_r;
    size_s         = size_r;
    mask_s         = mask_r;
    fill_data_s    = fill_data_r;
    fill_cnt_s     = fill_cnt_r;
    yield_cnt_s    = yield_cnt_r;
    a_ack_s        = 1'b0;
    b_ack_s        = 1'b0;
    a_rdata_s      = a_rdata_r;
    b_rdata_s      = b_rdata_r;
    mem_addr_s     = mem_addr_r;
    mem_wdata_s    = mem_wdata_r;
    mem_we_s       = 1'b0;
    mem_re_s       = 1'b0;
    busy_s         = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (grant_a_s) begin
          last_grant_a_s = 1'b1;
          side_a_s       = 1'b1;
          size_s         = EEPROMSize;
          mask_s         = in_mask_s;
          fill_data_s    = AData;
          fill_cnt_s     = ADDR_ZERO;
          yield_cnt_s    = YIELD_ZERO;
          mem_wdata_s    = AData;
          if (AOp == OP_READ) begin
            mem_addr_s = AAddr & in_mask_s;
            mem_re_s   = 1'b1;
          end else if (AOp == OP_FILL) begin
            mem_addr_s = ADDR_ZERO;
            mem_we_s   = (EEPROMSize != SIZE_NONE);
          end else begin
            mem_addr_s = AAddr & in_mask_s;
            mem_we_s   = (EEPROMSize != SIZE_NONE);
          end
        end else if (grant_b_s) begin
          last_grant_a_s = 1'b0;
          side_a_s       = 1'b0;
          size_s         = EEPROMSize;
          mask_s         = in_mask_s;
          mem_addr_s     = BAddr & in_mask_s;
          mem_wdata_s    = BData;
          mem_we_s       = BWrite & (EEPROMSize != SIZE_NONE);
          mem_re_s       = ~BWrite;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_ACC_WR: begin
        if (side_a_r) begin
          a_ack_s = 1'b1;
        end else begin
          b_ack_s = 1'b1;
        end
      end
      ST_ACC_RD: begin
        mem_re_s = 1'b0;
      end
      ST_RD_WAIT: begin
        if (side_a_r) begin
          a_ack_s   = 1'b1;
          a_rdata_s = read_value(size_r, MemRData);
        end else begin
          b_ack_s   = 1'b1;
          b_rdata_s = read_value(size_r, MemRData);
        end
      end
      ST_FILL: begin
        if (fill_last_s) begin
          a_ack_s = 1'b1;
        end else if (yield_go_s) begin
          // Park the fill on the next word and serve B with the fill's size.
          fill_cnt_s  = fill_cnt_r + ADDR_ONE;
          yield_cnt_s = yield_cnt_r + YIELD_ONE;
          mem_addr_s  = BAddr & mask_r;
          mem_wdata_s = BData;
          mem_we_s    = BWrite & fill_we_s;
          mem_re_s    = ~BWrite;
        end else begin
          fill_cnt_s  = fill_cnt_r + ADDR_ONE;
          yield_cnt_s = yield_cnt_r + YIELD_ONE;
          mem_addr_s  = fill_cnt_r + ADDR_ONE;
          mem_wdata_s = fill_data_r;
          mem_we_s    = fill_we_s;
        end
      end
      ST_YIELD_WR: begin
        b_ack_s     = 1'b1;
        mem_addr_s  = fill_cnt_r;
        mem_wdata_s = fill_data_r;
        mem_we_s    = fill_we_s;
      end
      ST_YIELD_RD: begin
        mem_re_s = 1'b0;
      end
      ST_YIELD_RDW: begin
        b_ack_s     = 1'b1;
        b_rdata_s   = read_value(size_r, MemRData);
        mem_addr_s  = fill_cnt_r;
        mem_wdata_s = fill_data_r;
        mem_we_s    = fill_we_s;
      end
      default: begin
        mem_we_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any access without an ack.
  always_ff @(posedge SClk) begin
    if (!nReset) begin
      last_grant_a_r <= 1'b0;
      side_a_r       <= 1'b0;
      size_r         <= 2'd0;
      mask_r         <= ADDR_ZERO;
      fill_data_r    <= 16'h0000;
      fill_cnt_r     <= ADDR_ZERO;
      yield_cnt_r    <= YIELD_ZERO;
      a_ack_r        <= 1'b0;
      b_ack_r        <= 1'b0;
      a_rdata_r      <= 16'h0000;
      b_rdata_r      <= 16'h0000;
      mem_addr_r     <= ADDR_ZERO;
      mem_wdata_r    <= 16'h0000;
      mem_we_r       <= 1'b0;
      mem_re_r       <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      last_grant_a_r <= last_grant_a_s;
      side_a_r       <= side_a_s;
      size_r         <= size_s;
      mask_r         <= mask_s;
      fill_data_r    <= fill_data_s;
      fill_cnt_r     <= fill_cnt_s;
      yield_cnt_r    <= yield_cnt_s;
      a_ack_r        <= a_ack_s;
      b_ack_r        <= b_ack_s;
      a_rdata_r      <= a_rdata_s;
      b_rdata_r      <= b_rdata_s;
      mem_addr_r     <= mem_addr_s;
      mem_wdata_r    <= mem_wdata_s;
      mem_we_r       <= mem_we_s;
      mem_re_r       <= mem_re_s;
      busy_r         <= busy_s;
    end
  end

  assign AAck     = a_ack_r;
  assign BAck     = b_ack_r;
  assign ARData   = a_rdata_r;
  assign BRData   = b_rdata_r;
  assign MemAddr  = mem_addr_r;
  assign MemWData = mem_wdata_r;
  assign MemWe    = mem_we_r;
  assign MemRe    = mem_re_r;
  assign Busy     = busy_r;

`ifdef EEPROM_DIRTY_TRACK_EN
  logic [15:0] dirty_r;
  logic [15:0] dirty_set_s;

  // Mark the 64-word block of the A write being committed on the RAM port.
  always_comb begin
    dirty_set_s = 16'h0000;
    if (mem_we_r && ((state_r == ST_FILL) || ((state_r == ST_ACC_WR) && side_a_r))) begin
      dirty_set_s[mem_addr_r[ADDR_WIDTH-1 -: 4]] = 1'b1;
    end else begin
      dirty_set_s = 16'h0000;
    end
  end

  // Dirty mask: clear requests first, so a same-cycle set survives.
  always_ff @(posedge SClk) begin
    if (!nReset) begin
      dirty_r <= 16'h0000;
    end else begin
      dirty_r <= (dirty_r & ~DirtyClr) | dirty_set_s;
    end
  end

  assign DirtyMask = dirty_r;
`endif

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Self-checking bench for eeprom_access_arbiter: table-driven single
// accesses plus hand-written fill/yield, reset, round-robin and (when
// EEPROM_DIRTY_TRACK_EN is defined) dirty-mask sequences.
`timescale 1ns/1ps
module tb_eeprom_access_arbiter;

  logic        SClk = 1'b0;
  logic        nReset;
  logic [1:0]  EEPROMSize;
  logic        AReq;
  logic [1:0]  AOp;
  logic [9:0]  AAddr;
  logic [15:0] AData;
  logic        AAck;
  logic [15:0] ARData;
  logic        BReq;
  logic        BWrite;
  logic [9:0]  BAddr;
  logic [15:0] BData;
  logic        BAck;
  logic [15:0] BRData;
  logic [9:0]  MemAddr;
  logic [15:0] MemWData;
  logic        MemWe;
  logic        MemRe;
  logic [15:0] MemRData;
  logic        Busy;
`ifdef EEPROM_DIRTY_TRACK_EN
  logic [15:0] DirtyMask;
  logic [15:0] DirtyClr;
`endif

  always #5 SClk = ~SClk;

  eeprom_access_arbiter dut (
    .SClk       (SClk),
    .nReset     (nReset),
    .EEPROMSize (EEPROMSize),
    .AReq       (AReq),
    .AOp        (AOp),
    .AAddr      (AAddr),
    .AData      (AData),
    .AAck       (AAck),
    .ARData     (ARData),
    .BReq       (BReq),
    .BWrite     (BWrite),
    .BAddr      (BAddr),
    .BData      (BData),
    .BAck       (BAck),
    .BRData     (BRData),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemWe      (MemWe),
    .MemRe      (MemRe),
    .MemRData   (MemRData),
    .Busy       (Busy)
`ifdef EEPROM_DIRTY_TRACK_EN
    ,
    .DirtyMask  (DirtyMask),
    .DirtyClr   (DirtyClr)
`endif
  );

  typedef struct {
    logic        side_a;    // 1 = port A, 0 = port B
    logic [1:0]  op;        // A: AOp; B: 1 = write, 0 = read
    logic [9:0]  addr;
    logic [15:0] data;
    logic [1:0]  size;
    logic [15:0] mrdata;    // value the RAM returns
    logic [9:0]  exp_addr;
    logic        exp_we;
    logic        exp_re;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [10];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_ardata = 16'h0000;
  logic [15:0] exp_brdata = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SClk);
    #1;
  endtask

  // One complete single access following the fixed T+1 / T+2 / T+3 timeline.
  task automatic run_vec(input vec_t v, input string tag);
    logic rd;
    rd = (v.op == 2'd0);
    EEPROMSize = v.size;
    MemRData   = v.mrdata;
    if (v.side_a) begin
      AReq = 1'b1; AOp = v.op; AAddr = v.addr; AData = v.data;
    end else begin
      BReq = 1'b1; BWrite = v.op[0]; BAddr = v.addr; BData = v.data;
    end
    step();
    check({tag, " MemAddr"}, 32'(MemAddr), 32'(v.exp_addr));
    check({tag, " MemWe"}, 32'(MemWe), 32'(v.exp_we));
    check({tag, " MemRe"}, 32'(MemRe), 32'(v.exp_re));
    check({tag, " Busy"}, 32'(Busy), 32'd1);
    if (!rd) begin
      check({tag, " MemWData"}, 32'(MemWData), 32'(v.data));
    end
    if (rd) begin
      step();
      check({tag, " early ack"}, 32'({AAck, BAck}), 32'd0);
      check({tag, " strobes idle"}, 32'({MemWe, MemRe}), 32'd0);
      if (v.side_a) exp_ardata = v.exp_rdata;
      else exp_brdata = v.exp_rdata;
    end
    step();
    check({tag, " ack"}, 32'({AAck, BAck}), v.side_a ? 32'd2 : 32'd1);
    check({tag, " Busy end"}, 32'(Busy), 32'd0);
    check({tag, " ARData"}, 32'(ARData), 32'(exp_ardata));
    check({tag, " BRData"}, 32'(BRData), 32'(exp_brdata));
    AReq = 1'b0;
    BReq = 1'b0;
    step();
    check({tag, " single ack"}, 32'({AAck, BAck}), 32'd0);
  endtask

  // Hard time limit; all waits below are already cycle-bounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wr_cnt, seq_err, a_acks, b_acks, both, extra, n;
    logic        done, ack_ok, back_ok, found, prev_we;
    logic [9:0]  prev_addr, e_addr;
    logic [15:0] e_data;
    logic [1:0]  order [3];
    logic [1:0]  first;

    //              side  op    addr    data      size  mrdata    exp_addr we    re    exp_rdata
    vecs[0] = '{1'b1, 2'd1, 10'h005, 16'h1234, 2'd2, 16'h0000, 10'h005, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 2'd0, 10'h245, 16'h0000, 2'd1, 16'hBEEF, 10'h045, 1'b0, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b1, 2'd0, 10'h245, 16'h0000, 2'd3, 16'hBEEF, 10'h245, 1'b0, 1'b1, 16'hFFFF};
    vecs[3] = '{1'b1, 2'd1, 10'h3AB, 16'h5555, 2'd3, 16'h0000, 10'h3AB, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 2'd1, 10'h3FF, 16'hA5A5, 2'd0, 16'h0000, 10'h03F, 1'b1, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 2'd0, 10'h1C7, 16'h0000, 2'd0, 16'h0F0F, 10'h007, 1'b0, 1'b1, 16'h0F0F};
    vecs[6] = '{1'b1, 2'd3, 10'h2A0, 16'hC3C3, 2'd2, 16'h0000, 10'h2A0, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 2'd0, 10'h155, 16'h0000, 2'd3, 16'h1111, 10'h155, 1'b0, 1'b1, 16'hFFFF};
    vecs[8] = '{1'b1, 2'd1, 10'h3FF, 16'h7E7E, 2'd1, 16'h0000, 10'h1FF, 1'b1, 1'b0, 16'h0000};
    vecs[9] = '{1'b1, 2'd0, 10'h3C0, 16'h0000, 2'd2, 16'h2468, 10'h3C0, 1'b0, 1'b1, 16'h2468};

    nReset = 1'b0; EEPROMSize = 2'd2; AReq = 1'b0; AOp = 2'd0; AAddr = 10'h000;
    AData = 16'h0000; BReq = 1'b0; BWrite = 1'b0; BAddr = 10'h000; BData = 16'h0000;
    MemRData = 16'h0000;
`ifdef EEPROM_DIRTY_TRACK_EN
    DirtyClr = 16'h0000;
`endif
    step();
    step();
    check("reset outputs", 32'({AAck, BAck, MemWe, MemRe, Busy}), 32'd0);
    check("reset MemAddr", 32'(MemAddr), 32'd0);
    check("reset rdata", 32'({ARData, BRData}), 32'd0);
`ifdef EEPROM_DIRTY_TRACK_EN
    check("reset DirtyMask", 32'(DirtyMask), 32'd0);
`endif
    nReset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Fill 0xFFFF over a 1KB part while B holds a write from word 3 onward.
    EEPROMSize = 2'd1; AReq = 1'b1; AOp = 2'd2; AAddr = 10'h155; AData = 16'hFFFF;
    BWrite = 1'b1; BAddr = 10'h0C5; BData = 16'h1357;
    wr_cnt = 0; seq_err = 0; a_acks = 0; b_acks = 0; both = 0;
    done = 1'b0; ack_ok = 1'b0; back_ok = 1'b0; prev_we = 1'b0; prev_addr = 10'h000;
    for (int c = 0; c < 700 && !done; c++) begin
      step();
      if (MemWe && MemRe) both++;
      if (AAck) begin
        a_acks++;
        if (prev_we && prev_addr == 10'h1FF && wr_cnt == 513) ack_ok = 1'b1;
        AReq = 1'b0;
        done = 1'b1;
      end
      if (BAck) begin
        b_acks++;
        if (prev_we && prev_addr == 10'h0C5 && wr_cnt == 17) back_ok = 1'b1;
        BReq = 1'b0;
      end
      if (MemWe) begin
        if (wr_cnt < 16) begin
          e_addr = 10'(wr_cnt); e_data = 16'hFFFF;
        end else if (wr_cnt == 16) begin
          e_addr = 10'h0C5; e_data = 16'h1357;
        end else begin
          e_addr = 10'(wr_cnt - 1); e_data = 16'hFFFF;
        end
        if (MemAddr !== e_addr || MemWData !== e_data) seq_err++;
        if (wr_cnt == 3) BReq = 1'b1;
        wr_cnt++;
      end
      prev_we = MemWe;
      prev_addr = MemAddr;
    end
    check("fill completed", 32'(done), 32'd1);
    check("fill write count", 32'(wr_cnt), 32'd513);
    check("fill write order", 32'(seq_err), 32'd0);
    check("fill AAck count", 32'(a_acks), 32'd1);
    check("fill AAck after last word", 32'(ack_ok), 32'd1);
    check("fill BAck count", 32'(b_acks), 32'd1);
    check("fill BAck after B write", 32'(back_ok), 32'd1);
    check("fill we/re overlap", 32'(both), 32'd0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (AAck || BAck || MemWe) extra++;
    end
    check("fill quiet after ack", 32'(extra), 32'd0);
    check("fill Busy after", 32'(Busy), 32'd0);

    // Reset lands while fill word 7 is on the RAM port.
    EEPROMSize = 2'd2; AReq = 1'b1; AOp = 2'd2; AData = 16'hABCD; found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      step();
      if (MemWe && MemAddr == 10'h007) begin
        found = 1'b1;
        nReset = 1'b0;
        AReq = 1'b0;
      end
    end
    check("midfill word 7 seen", 32'(found), 32'd1);
    step();
    check("midfill reset strobes", 32'({AAck, BAck, MemWe, MemRe, Busy}), 32'd0);
    check("midfill reset MemAddr", 32'(MemAddr), 32'd0);
    check("midfill reset MemWData", 32'(MemWData), 32'd0);
    check("midfill reset ARData", 32'(ARData), 32'd0);
    check("midfill reset BRData", 32'(BRData), 32'd0);
    exp_ardata = 16'h0000;
    exp_brdata = 16'h0000;
    nReset = 1'b1;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (AAck || MemWe || Busy) extra++;
    end
    check("midfill abandoned", 32'(extra), 32'd0);

    // Both requesters held from the same cycle: grants go A, B, A.
    EEPROMSize = 2'd2; AReq = 1'b1; AOp = 2'd1; AAddr = 10'h010; AData = 16'h1111;
    BReq = 1'b1; BWrite = 1'b1; BAddr = 10'h020; BData = 16'h2222;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      step();
      if (AAck && n < 3) begin order[n] = 2'd1; n++; end
      if (BAck && n < 3) begin order[n] = 2'd2; n++; end
      if (n == 3) begin AReq = 1'b0; BReq = 1'b0; end
    end
    check("rr ack count", 32'(n), 32'd3);
    check("rr grant 1", 32'(order[0]), 32'd1);
    check("rr grant 2", 32'(order[1]), 32'd2);
    check("rr grant 3", 32'(order[2]), 32'd1);
    step();

    // Last grant was A, so a simultaneous pair goes to B first.
    AReq = 1'b1; BReq = 1'b1; first = 2'd0;
    for (int c = 0; c < 10 && first == 2'd0; c++) begin
      step();
      if (AAck) first = 2'd1;
      else if (BAck) first = 2'd2;
      else first = 2'd0;
      if (first != 2'd0) begin AReq = 1'b0; BReq = 1'b0; end
    end
    check("rr after A goes B", 32'(first), 32'd2);
    step();
    step();
    check("rr idle after", 32'({Busy, AAck, BAck}), 32'd0);

`ifdef EEPROM_DIRTY_TRACK_EN
    DirtyClr = 16'hFFFF;
    step();
    DirtyClr = 16'h0000;
    step();
    check("dirty cleared", 32'(DirtyMask), 32'd0);
    run_vec('{1'b1, 2'd1, 10'h0C1, 16'h0001, 2'd2, 16'h0000, 10'h0C1, 1'b1, 1'b0, 16'h0000}, "dirty A 0C1");
    check("dirty after 0C1", 32'(DirtyMask), 32'h0008);
    EEPROMSize = 2'd2; AReq = 1'b1; AOp = 2'd1; AAddr = 10'h0C2; AData = 16'h0002;
    step();
    DirtyClr = 16'h0008;
    step();
    DirtyClr = 16'h0000;
    check("dirty set wins", 32'(DirtyMask), 32'h0008);
    AReq = 1'b0;
    step();
    run_vec('{1'b0, 2'd1, 10'h100, 16'h0003, 2'd2, 16'h0000, 10'h100, 1'b1, 1'b0, 16'h0000}, "dirty B 100");
    check("dirty B no set", 32'(DirtyMask), 32'h0008);
    DirtyClr = 16'h0008;
    step();
    DirtyClr = 16'h0000;
    step();
    check("dirty clr alone", 32'(DirtyMask), 32'h0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
